decode_ctrl_stage: RTL and testbench



---
 rtl/decode_ctrl_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I(+M) decode stage: one instruction per handshake, control bundle one cycle later.
// An M op leaving the stage holds off issue for MD_LAT cycles to model one iterative mul/div unit.
module decode_ctrl_stage #(
    parameter int ENABLE_M = 1,
    parameter int MD_LAT   = 32,
    parameter int PC_W     = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] out_pc_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            alu_imm_sel_o,
    output logic            alu_pc_sel_o,
    output logic [5:0]      br_o,
    output logic            jal_o,
    output logic            jalr_o,
    output logic [2:0]      rw_type_o,
    output logic [4:0]      alu_ctl_o,
    output logic            muldiv_o,
    output logic            illegal_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU codes are {alt, funct3}: alt selects SUB (funct3=000) and SRA (funct3=101)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b1000;

    localparam int CW = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;
    localparam int BW = 28;

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opimm, is_op;
    logic            is_m, illegal, reg_write;
    logic [4:0]      alu;
    logic [5:0]      br;
    logic [BW-1:0]   bndl_d, bndl_q;
    logic [PC_W-1:0] pc_q;
    logic            out_valid_d, out_valid_q;
    logic [CW-1:0]   md_cnt_d, md_cnt_q;
    logic            load, handoff;
    logic            unused_instr;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign unused_instr = ^instr_i[24:15];

    assign is_lui   = (opc == OPC_LUI);
    assign is_auipc = (opc == OPC_AUIPC);
    assign is_jal   = (opc == OPC_JAL);
    assign is_jalr  = (opc == OPC_JALR);
    assign is_br    = (opc == OPC_BRANCH);
    assign is_ld    = (opc == OPC_LOAD);
    assign is_st    = (opc == OPC_STORE);
    assign is_opimm = (opc == OPC_OPIMM);
    assign is_op    = (opc == OPC_OP);

    assign is_m = is_op && (f7 == 7'b0000001) && (ENABLE_M != 0);

    assign illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld || is_st ||
                       is_opimm || is_op)
                  || (is_br && (f3[2:1] == 2'b01))
                  || (is_op && !((f7 == 7'b0000000) || (f7 == 7'b0100000) || is_m));

    assign reg_write = (instr_i[11:7] != 5'd0) && !illegal &&
                       (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opimm || is_op);

    // Immediate shifts carry instr[30] as SRAI; for other OP-IMM it is just an immediate bit
    always_comb begin
        alu = {1'b0, ALU_ADD};
        if (is_m) begin
            alu = {2'b10, f3};
        end else if (is_op || is_opimm) begin
            alu = {1'b0, instr_i[30] && ((f3 == 3'b101) || (is_op && (f3 == 3'b000))), f3};
        end else if (is_br) begin
            case (f3[2:1])
                2'b00:   alu = {1'b0, ALU_SUB};
                2'b10:   alu = {1'b0, ALU_SLT};
                2'b11:   alu = {1'b0, ALU_SLTU};
                default: alu = {1'b0, ALU_ADD};
            endcase
        end
    end

    always_comb begin
        br = 6'b000000;
        if (is_br && !illegal) begin
            case (f3)
                3'b000:  br = 6'b000001;
                3'b001:  br = 6'b000010;
                3'b100:  br = 6'b000100;
                3'b101:  br = 6'b001000;
                3'b110:  br = 6'b010000;
                3'b111:  br = 6'b100000;
                default: br = 6'b000000;
            endcase
        end
    end

    assign bndl_d = {instr_i[11:7], reg_write, is_ld && !illegal, is_st && !illegal,
                     is_lui || is_auipc || is_jalr || is_ld || is_st || is_opimm, is_auipc,
                     br, is_jal && !illegal, is_jalr && !illegal, f3, alu,
                     is_m && !illegal, illegal};

    assign {rd_o, reg_write_o, mem_read_o, mem_write_o, alu_imm_sel_o, alu_pc_sel_o,
            br_o, jal_o, jalr_o, rw_type_o, alu_ctl_o, muldiv_o, illegal_o} = bndl_q;
    assign out_pc_o    = pc_q;
    assign out_valid_o = out_valid_q;

    assign in_ready_o = !rst_i && (md_cnt_q == '0) && (!out_valid_q || out_ready_i);
    assign load       = in_valid_i && in_ready_o && !flush_i;
    assign handoff    = out_valid_q && out_ready_i;

    // Flush beats load, drain and the busy window alike
    always_comb begin
        out_valid_d = out_valid_q;
        md_cnt_d    = md_cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            md_cnt_d    = '0;
        end else begin
            if (load)         out_valid_d = 1'b1;
            else if (handoff) out_valid_d = 1'b0;
            if (handoff && muldiv_o && (MD_LAT > 0)) md_cnt_d = CW'(MD_LAT);
            else if (md_cnt_q != '0)                 md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            md_cnt_q    <= '0;
            bndl_q      <= '0;
            pc_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            md_cnt_q    <= md_cnt_d;
            if (load) begin
                bndl_q <= bndl_d;
                pc_q   <= in_pc_i;
            end
        end
    end
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: decode vector table, hand-written handshake/stall/flush/reset
// sequences, then randomized traffic against a rule-level reference model.
module tb_decode_ctrl_stage;
    localparam int LAT = 4;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw, mr, mw, imm, pcs;
        logic [5:0] br;
        logic       jal, jalr;
        logic [2:0] rwt;
        logic [4:0] alu;
        logic       md, ill;
    } bndl_t;

    typedef struct {
        logic [31:0] instr;
        bndl_t       exp;
    } vec_t;

    localparam logic [4:0] A_ADD = 5'b00000, A_SLL = 5'b00001, A_SLT = 5'b00010,
                           A_SLTU = 5'b00011, A_XOR = 5'b00100, A_SRL = 5'b00101,
                           A_OR = 5'b00110, A_AND = 5'b00111, A_SUB = 5'b01000,
                           A_SRA = 5'b01101;

    logic        clk, rst, flush, in_valid, out_ready;
    logic [31:0] instr, in_pc;
    logic        in_ready, out_valid, rw, mr, mw, imm, pcs, jal, jalr, md, ill;
    logic [31:0] out_pc;
    logic [4:0]  rd, alu;
    logic [5:0]  br;
    logic [2:0]  rwt;
    logic        in_ready0, out_valid0, rw0, mr0, mw0, imm0, pcs0, jal0, jalr0, md0, ill0;
    logic [31:0] out_pc0;
    logic [4:0]  rd0, unused_alu0;
    logic [5:0]  br0;
    logic [2:0]  rwt0;
    bndl_t       act, act0;

    int checks = 0;
    int failures = 0;

    decode_ctrl_stage #(.ENABLE_M(1), .MD_LAT(LAT), .PC_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .rd_o(rd), .reg_write_o(rw), .mem_read_o(mr), .mem_write_o(mw),
        .alu_imm_sel_o(imm), .alu_pc_sel_o(pcs), .br_o(br), .jal_o(jal), .jalr_o(jalr),
        .rw_type_o(rwt), .alu_ctl_o(alu), .muldiv_o(md), .illegal_o(ill));

    decode_ctrl_stage #(.ENABLE_M(0), .MD_LAT(0), .PC_W(32)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .instr_i(instr), .in_pc_i(in_pc), .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .out_pc_o(out_pc0), .rd_o(rd0), .reg_write_o(rw0), .mem_read_o(mr0), .mem_write_o(mw0),
        .alu_imm_sel_o(imm0), .alu_pc_sel_o(pcs0), .br_o(br0), .jal_o(jal0), .jalr_o(jalr0),
        .rw_type_o(rwt0), .alu_ctl_o(unused_alu0), .muldiv_o(md0), .illegal_o(ill0));

    assign act  = {rd, rw, mr, mw, imm, pcs, br, jal, jalr, rwt, alu, md, ill};
    assign act0 = {rd0, rw0, mr0, mw0, imm0, pcs0, br0, jal0, jalr0, rwt0, 5'b00000, md0, ill0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, time=%0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", nm, a, e);
        end
    endtask

    // en = {reg_write, mem_read, mem_write, alu_imm_sel, alu_pc_sel}; jj = {jal, jalr}; mi = {muldiv, illegal}
    function automatic bndl_t mk(input logic [4:0] r, input logic [4:0] en, input logic [5:0] b,
                                 input logic [1:0] jj, input logic [2:0] t, input logic [4:0] a,
                                 input logic [1:0] mi);
        return {r, en, b, jj, t, a, mi};
    endfunction

    // ALU code is not defined for illegal encodings, so it is excluded there
    function automatic logic [63:0] msk(input bndl_t b, input logic ignore_alu);
        bndl_t t;
        t = b;
        if (ignore_alu) t.alu = 5'b00000;
        return 64'(t);
    endfunction

    function automatic bndl_t ref_dec(input logic [31:0] ins, input bit en_m);
        bndl_t b;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit lui, auipc, j, jr, brn, ld, st, opi, opr, mop, bad;
        b   = '0;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        lui = (op == 7'h37); auipc = (op == 7'h17); j = (op == 7'h6F); jr = (op == 7'h67);
        brn = (op == 7'h63); ld = (op == 7'h03); st = (op == 7'h23);
        opi = (op == 7'h13); opr = (op == 7'h33);
        mop = opr && (f7 == 7'h01) && en_m;
        bad = !(lui || auipc || j || jr || brn || ld || st || opi || opr)
           || (brn && (f3 == 3'd2 || f3 == 3'd3))
           || (opr && !(f7 == 7'h00 || f7 == 7'h20 || mop));
        b.rd  = ins[11:7];
        b.rwt = f3;
        b.ill = bad;
        b.imm = lui || auipc || jr || ld || st || opi;
        b.pcs = auipc;
        if (!bad) begin
            b.rw   = (ins[11:7] != 5'd0) && (lui || auipc || j || jr || ld || opi || opr);
            b.mr   = ld;
            b.mw   = st;
            b.jal  = j;
            b.jalr = jr;
            b.md   = mop;
            if (brn) b.br = 6'b000001 << ((f3 < 3'd2) ? f3 : f3 - 3'd2);
        end
        if (mop) b.alu = {2'b10, f3};
        else if (opr || opi) begin
            case (f3)
                3'd0: b.alu = (opr && ins[30]) ? A_SUB : A_ADD;
                3'd1: b.alu = A_SLL;
                3'd2: b.alu = A_SLT;
                3'd3: b.alu = A_SLTU;
                3'd4: b.alu = A_XOR;
                3'd5: b.alu = ins[30] ? A_SRA : A_SRL;
                3'd6: b.alu = A_OR;
                default: b.alu = A_AND;
            endcase
        end else if (brn) begin
            if (f3 < 3'd2)      b.alu = A_SUB;
            else if (f3 < 3'd6) b.alu = A_SLT;
            else                b.alu = A_SLTU;
        end else b.alu = A_ADD;
        return b;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r;
        logic [6:0]  op, f7;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;  4: op = 7'h63;
            5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;  8: op = 7'h33;
            default: op = r[6:0];
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
            default: f7 = r[31:25];
        endcase
        return {f7, r[24:7], op};
    endfunction

    vec_t  tbl[21];
    bndl_t e_mul, e_mul0, m_b;
    bit    m_valid, exp_rdy, take, hand;
    int    m_busy, n;
    logic [31:0] m_pc;

    initial begin
        tbl[0]  = '{32'h00500093, mk(5'd1,  5'b10010, 6'b000000, 2'b00, 3'd0, A_ADD,  2'b00)};
        tbl[1]  = '{32'h00000013, mk(5'd0,  5'b00010, 6'b000000, 2'b00, 3'd0, A_ADD,  2'b00)};
        tbl[2]  = '{32'h402081B3, mk(5'd3,  5'b10000, 6'b000000, 2'b00, 3'd0, A_SUB,  2'b00)};
        tbl[3]  = '{32'h00208463, mk(5'd8,  5'b00000, 6'b000001, 2'b00, 3'd0, A_SUB,  2'b00)};
        tbl[4]  = '{32'h0000000B, mk(5'd0,  5'b00000, 6'b000000, 2'b00, 3'd0, A_ADD,  2'b01)};
        tbl[5]  = '{32'h0020A463, mk(5'd8,  5'b00000, 6'b000000, 2'b00, 3'd2, A_ADD,  2'b01)};
        tbl[6]  = '{32'h00812203, mk(5'd4,  5'b11010, 6'b000000, 2'b00, 3'd2, A_ADD,  2'b00)};
        tbl[7]  = '{32'h00512623, mk(5'd12, 5'b00110, 6'b000000, 2'b00, 3'd2, A_ADD,  2'b00)};
        tbl[8]  = '{32'h123453B7, mk(5'd7,  5'b10010, 6'b000000, 2'b00, 3'd5, A_ADD,  2'b00)};
        tbl[9]  = '{32'h00001417, mk(5'd8,  5'b10011, 6'b000000, 2'b00, 3'd1, A_ADD,  2'b00)};
        tbl[10] = '{32'h010000EF, mk(5'd1,  5'b10000, 6'b000000, 2'b10, 3'd0, A_ADD,  2'b00)};
        tbl[11] = '{32'h00008067, mk(5'd0,  5'b00010, 6'b000000, 2'b01, 3'd0, A_ADD,  2'b00)};
        tbl[12] = '{32'h4034D493, mk(5'd9,  5'b10010, 6'b000000, 2'b00, 3'd5, A_SRA,  2'b00)};
        tbl[13] = '{32'h042081B3, mk(5'd3,  5'b00000, 6'b000000, 2'b00, 3'd0, A_ADD,  2'b01)};
        tbl[14] = '{32'h0020E463, mk(5'd8,  5'b00000, 6'b010000, 2'b00, 3'd6, A_SLTU, 2'b00)};
        tbl[15] = '{32'h0020D463, mk(5'd8,  5'b00000, 6'b001000, 2'b00, 3'd5, A_SLT,  2'b00)};
        tbl[16] = '{32'h0020C1B3, mk(5'd3,  5'b10000, 6'b000000, 2'b00, 3'd4, A_XOR,  2'b00)};
        tbl[17] = '{32'h40000093, mk(5'd1,  5'b10010, 6'b000000, 2'b00, 3'd0, A_ADD,  2'b00)};
        tbl[18] = '{32'h4020D1B3, mk(5'd3,  5'b10000, 6'b000000, 2'b00, 3'd5, A_SRA,  2'b00)};
        tbl[19] = '{32'h00209463, mk(5'd8,  5'b00000, 6'b000010, 2'b00, 3'd1, A_SUB,  2'b00)};
        tbl[20] = '{32'h402091B3, mk(5'd3,  5'b10000, 6'b000000, 2'b00, 3'd1, A_SLL,  2'b00)};
        e_mul  = mk(5'd5, 5'b10000, 6'b000000, 2'b00, 3'd0, 5'b10000, 2'b10);
        e_mul0 = mk(5'd5, 5'b00000, 6'b000000, 2'b00, 3'd0, 5'b00000, 2'b01);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; in_pc = 32'h0;
        tick(); tick(); settle();
        chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_bundle", 64'(act), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        rst = 1'b0;
        settle();
        chk("post_rst_in_ready", 64'(in_ready), 64'(1'b1));

        // Decode table streamed at one per cycle
        for (int i = 0; i < 21; i++) begin
            instr = tbl[i].instr; in_pc = 32'(32'h1000 + i * 4);
            in_valid = 1'b1; out_ready = 1'b1;
            settle();
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(1'b1));
            tick();
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(1'b1));
            chk($sformatf("tbl%0d_pc", i), 64'(out_pc), 64'(32'(32'h1000 + i * 4)));
            chk($sformatf("tbl%0d_bundle", i), msk(act, tbl[i].exp.ill), msk(tbl[i].exp, tbl[i].exp.ill));
        end

        // Drain, then backpressure on a SUB with a BEQ waiting
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'(1'b0));
        instr = tbl[2].instr; in_pc = 32'h2000; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        instr = tbl[3].instr; in_pc = 32'h2004;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'(1'b0));
            tick();
            chk($sformatf("bp%0d_valid", k), 64'(out_valid), 64'(1'b1));
            chk($sformatf("bp%0d_bundle", k), 64'(act), 64'(tbl[2].exp));
            chk($sformatf("bp%0d_pc", k), 64'(out_pc), 64'(32'h2000));
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_in_ready", 64'(in_ready), 64'(1'b1));
        tick();
        chk("bp_beq_bundle", 64'(act), 64'(tbl[3].exp));
        chk("bp_beq_pc", 64'(out_pc), 64'(32'h2004));

        // MUL: decoded as M op, stalls issue LAT cycles after handoff; illegal with M disabled
        instr = 32'h027302B3; in_pc = 32'h3000; in_valid = 1'b1;
        tick();
        chk("mul_bundle", 64'(act), 64'(e_mul));
        chk("mul_noM_bundle", msk(act0, 1'b1), msk(e_mul0, 1'b1));
        in_valid = 1'b0;
        tick();
        settle();
        chk("mul_noM_no_stall", 64'(in_ready0), 64'(1'b1));
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            n++;
            tick(); settle();
        end
        chk("mul_stall_cycles", 64'(n), 64'(LAT));

        // Flush while FULL and backpressured: held bundle and presented input both dropped
        instr = tbl[0].instr; in_pc = 32'h4000; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        instr = tbl[6].instr; in_pc = 32'h4004; out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", 64'(out_valid), 64'(1'b0));
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        settle();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_input", 64'(out_valid), 64'(1'b0));

        // Flush two cycles into the busy window
        instr = 32'h027302B3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        settle();
        chk("md_busy_before_flush", 64'(in_ready), 64'(1'b0));
        tick();
        flush = 1'b0;
        settle();
        chk("md_flush_in_ready", 64'(in_ready), 64'(1'b1));

        // Flush on the M-op handoff cycle: no busy window starts
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        chk("flush_handoff_in_ready", 64'(in_ready), 64'(1'b1));
        chk("flush_handoff_valid", 64'(out_valid), 64'(1'b0));
        tick();
        chk("flush_handoff_in_ready2", 64'(in_ready), 64'(1'b1));

        // Reset while FULL and busy
        instr = 32'h027302B3; in_pc = 32'h5000; in_valid = 1'b1;
        tick();
        instr = tbl[0].instr; in_pc = 32'h5004;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        settle();
        chk("pre_rst_full", 64'(out_valid), 64'(1'b1));
        chk("pre_rst_busy", 64'(in_ready), 64'(1'b0));
        rst = 1'b1;
        tick();
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1'b0));
        rst = 1'b0;
        settle();
        chk("rst2_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst2_bundle", 64'(act), 64'd0);
        chk("rst2_out_pc", 64'(out_pc), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'(1'b1));

        // Randomized traffic against the reference model
        m_valid = 1'b0; m_busy = 0; m_b = '0; m_pc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            instr     = gen();
            in_pc     = $urandom();
            settle();
            exp_rdy = (m_busy == 0) && (!m_valid || out_ready);
            chk($sformatf("rnd%0d_in_ready", c), 64'(in_ready), 64'(exp_rdy));
            take = in_valid && exp_rdy && !flush;
            hand = m_valid && out_ready;
            tick();
            if (flush) begin
                m_valid = 1'b0;
                m_busy  = 0;
            end else begin
                if (hand && m_b.md) m_busy = LAT;
                else if (m_busy > 0) m_busy--;
                if (take) begin
                    m_valid = 1'b1;
                    m_b     = ref_dec(instr, 1'b1);
                    m_pc    = in_pc;
                end else if (hand) m_valid = 1'b0;
            end
            chk($sformatf("rnd%0d_out_valid", c), 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk($sformatf("rnd%0d_bundle", c), msk(act, m_b.ill), msk(m_b, m_b.ill));
                chk($sformatf("rnd%0d_pc", c), 64'(out_pc), 64'(m_pc));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
